// File: rtl/mmu_dcache.sv
// -----------------------------------------------------------------------------
// mmu_dcache
//   Set-associative, write-through, no-write-allocate data cache that sits
//   between the core load/store port and the memory arbiter bus. There is one
//   word per line. Load hits answer from the local tag/data arrays. Load misses
//   fill a victim way from the arbiter. Every store is written through to the
//   arbiter. A store that hits also updates the cached word in place.
//
//   Victim selection picks the lowest-numbered invalid way in the set. When
//   every way is valid, it uses the set's round-robin pointer. The pointer
//   advances on every fill.
//
// Parameters
//   ADDR_W  byte-address width
//   DATA_W  word width (power of two, >= 8)
//   SETS    number of sets (power of two, >= 2)
//   WAYS    ways per set (power of two, >= 2)
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   req_valid/we/addr/wdata    core request (sampled only while req_ready=1)
//   req_ready                  high only in IDLE
//   resp_valid/resp_rdata      one-cycle completion pulse; rdata=0 for stores
//   mem_req/we/addr/wdata      arbiter request, held until mem_ack
//   mem_ack/mem_rdata          arbiter completion pulse with read data
//   perf_hits/perf_misses      saturating load hit/miss counters
//                              (only when MMU_DCACHE_PERF_EN is defined)
//
// Configuration macro: MMU_DCACHE_PERF_EN
// -----------------------------------------------------------------------------
module mmu_dcache #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SETS   = 4,
   parameter int WAYS   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
`ifdef MMU_DCACHE_PERF_EN
   output logic [31:0]       perf_hits,
   output logic [31:0]       perf_misses,
`endif
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int OFF   = $clog2(DATA_W / 8);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int TAG_W = ADDR_W - OFF - IDX_W;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF;

   typedef enum logic [1:0] {S_IDLE, S_RESP, S_FILL, S_WRITE} state_t;

   state_t              state_q, state_d;
   logic                req_ready_q, req_ready_d;
   logic                resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [SETS-1:0][WAYS-1:0]  valid_q, valid_d;
   logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;

   logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
   logic [DATA_W-1:0] data_mem [SETS][WAYS];

   // Array write port: one write per cycle, either a store hit or a fill.
   logic              arr_we, arr_tag_we;
   logic [IDX_W-1:0]  arr_idx;
   logic [WAY_W-1:0]  arr_way;
   logic [TAG_W-1:0]  arr_tag;
   logic [DATA_W-1:0] arr_data;

   // Lookup uses the live core address. The fill uses the latched, aligned
   // address held on mem_addr.
   logic [IDX_W-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0] req_tag, fill_tag;
   logic             hit;
   logic [WAY_W-1:0] hit_way, victim;

   assign req_idx  = req_addr[OFF +: IDX_W];
   assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
   assign fill_idx = mem_addr_q[OFF +: IDX_W];
   assign fill_tag = mem_addr_q[ADDR_W-1 -: TAG_W];

   // Scanning from the top way down means the lowest matching way is written
   // last and wins.
   always_comb begin : lookup
      // NOTE: every variable written in an always_comb gets a default first;
      // a path that leaves it unassigned would infer a latch.
      hit     = 1'b0;
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   always_comb begin : victim_sel
      victim = rr_q[fill_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[fill_idx][w]) victim = WAY_W'(w);
      end
   end

   always_comb begin : next_state
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      valid_d      = valid_q;
      rr_d         = rr_q;
      arr_we       = 1'b0;
      arr_tag_we   = 1'b0;
      arr_idx      = req_idx;
      arr_way      = hit_way;
      arr_tag      = fill_tag;
      arr_data     = req_wdata;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               mem_addr_d  = req_addr & ALIGN_MASK;
               if (req_we) begin
                  state_d     = S_WRITE;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = req_wdata;
                  arr_we      = hit;          // update in place, never allocate
               end else if (hit) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = data_mem[req_idx][hit_way];
               end else begin
                  state_d   = S_FILL;
                  mem_req_d = 1'b1;
                  mem_we_d  = 1'b0;
               end
            end
         end
         S_FILL: begin
            if (mem_ack) begin
               arr_we                    = 1'b1;
               arr_tag_we                = 1'b1;
               arr_idx                   = fill_idx;
               arr_way                   = victim;
               arr_data                  = mem_rdata;
               valid_d[fill_idx][victim] = 1'b1;
               rr_d[fill_idx]            = rr_q[fill_idx] + WAY_W'(1);
               mem_req_d                 = 1'b0;
               state_d                   = S_RESP;
               resp_valid_d              = 1'b1;
               resp_rdata_d              = mem_rdata;
            end
         end
         S_WRITE: begin
            if (mem_ack) begin
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
            end
         end
         S_RESP: begin
            resp_valid_d = 1'b0;
            resp_rdata_d = '0;
            req_ready_d  = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin : fsm_regs
      // NOTE: sequential state uses non-blocking assignments so that every
      // flop samples its pre-edge inputs, regardless of statement order.
      if (reset) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         valid_q      <= '0;
         rr_q         <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         valid_q      <= valid_d;
         rr_q         <= rr_d;
      end
   end

   // NOTE: the tag/data arrays have no reset. The valid bits alone decide
   // whether an entry is meaningful, so this logic can map onto plain RAM.
   always_ff @(posedge clk) begin : arrays
      if (arr_we && !reset) begin
         data_mem[arr_idx][arr_way] <= arr_data;
         if (arr_tag_we) tag_mem[arr_idx][arr_way] <= arr_tag;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

`ifdef MMU_DCACHE_PERF_EN
   logic [31:0] perf_hits_q, perf_hits_d;
   logic [31:0] perf_misses_q, perf_misses_d;

   always_comb begin : perf_next
      perf_hits_d   = perf_hits_q;
      perf_misses_d = perf_misses_q;
      if ((state_q == S_IDLE) && req_valid && req_ready_q && !req_we) begin
         if (hit) begin
            if (perf_hits_q != '1) perf_hits_d = perf_hits_q + 32'd1;
         end else begin
            if (perf_misses_q != '1) perf_misses_d = perf_misses_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin : perf_regs
      if (reset) begin
         perf_hits_q   <= '0;
         perf_misses_q <= '0;
      end else begin
         perf_hits_q   <= perf_hits_d;
         perf_misses_q <= perf_misses_d;
      end
   end

   assign perf_hits   = perf_hits_q;
   assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_mmu_dcache.sv
// -----------------------------------------------------------------------------
// tb_mmu_dcache
//   Self-checking bench for mmu_dcache in its default configuration
//   (4 sets x 4 ways, 32-bit words). The bench plays the role of the arbiter.
//   It keeps a memory model of its own. The expected load data comes from
//   that model and is queued when a request is issued. The queue is popped
//   when resp_valid appears. Hit or miss expectations come from the
//   replacement behaviour of the cache.
// -----------------------------------------------------------------------------
module tb_mmu_dcache;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
`ifdef MMU_DCACHE_PERF_EN
   logic [31:0] perf_hits, perf_misses;
`endif

   int checks   = 0;
   int failures = 0;
   int ack_wait = 1;

   logic [31:0] exp_q[$];
   logic [31:0] mem_model [logic [31:0]];

   always #5 clk = ~clk;

   mmu_dcache dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
`ifdef MMU_DCACHE_PERF_EN
      .perf_hits  (perf_hits),
      .perf_misses(perf_misses),
`endif
      .mem_rdata  (mem_rdata)
   );

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic fail(input string name, input logic [31:0] got, input logic [31:0] exp);
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
   endtask

   // Reset while sampling the outputs. The check is #1 after assertion, so it
   // also proves the reset acts asynchronously.
   task automatic apply_reset(input string name);
      #2 reset = 1'b1;
      #1;
      checks++; if (req_ready  !== 1'b1)  fail({name, "_req_ready"},  32'(req_ready),  32'd1);
      checks++; if (resp_valid !== 1'b0)  fail({name, "_resp_valid"}, 32'(resp_valid), 32'd0);
      checks++; if (mem_req    !== 1'b0)  fail({name, "_mem_req"},    32'(mem_req),    32'd0);
      checks++; if (mem_we     !== 1'b0)  fail({name, "_mem_we"},     32'(mem_we),     32'd0);
      checks++; if (mem_addr   !== 32'h0) fail({name, "_mem_addr"},   mem_addr,        32'h0);
      checks++; if (resp_rdata !== 32'h0) fail({name, "_resp_rdata"}, resp_rdata,      32'h0);
`ifdef MMU_DCACHE_PERF_EN
      checks++; if (perf_hits   !== 32'h0) fail({name, "_perf_hits"},   perf_hits,   32'h0);
      checks++; if (perf_misses !== 32'h0) fail({name, "_perf_misses"}, perf_misses, 32'h0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Issue one request and act as the arbiter until the response comes back.
   // exp_mem says whether an arbiter transaction must occur (miss or store).
   task automatic issue(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_mem);
      logic [31:0] aligned, expv;
      int          waits, cyc;
      bit          acked, seen_mem, done;
      aligned = addr & 32'hFFFF_FFFC;
      exp_q.push_back(we ? 32'h0 : mem_read(aligned));
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) fail({name, "_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0; req_we = $urandom_range(1); req_addr = $urandom; req_wdata = $urandom;
      cyc = 1; waits = 0; acked = 0; seen_mem = 0; done = 0;
      while (!done && cyc <= 50) begin
         mem_ack = 1'b0;
         if (mem_req) begin
            if (acked) begin
               checks++; fail({name, "_mem_req_after_ack"}, 32'd1, 32'd0);
            end else if (!seen_mem) begin
               seen_mem = 1;
               checks++; if (mem_addr !== aligned) fail({name, "_mem_addr"}, mem_addr, aligned);
               checks++; if (mem_we !== we) fail({name, "_mem_we"}, 32'(mem_we), 32'(we));
               if (we) begin
                  checks++; if (mem_wdata !== wdata) fail({name, "_mem_wdata"}, mem_wdata, wdata);
               end
            end
            if (!acked) begin
               if (waits == ack_wait) begin
                  mem_ack = 1'b1; acked = 1;
                  if (we) mem_model[aligned] = wdata;
                  else    mem_rdata = mem_read(aligned);
               end else begin
                  waits++; mem_rdata = $urandom;
               end
            end
         end
         if (resp_valid) begin
            expv = exp_q.pop_front();
            checks++; if (resp_rdata !== expv) fail({name, "_rdata"}, resp_rdata, expv);
            checks++; if (seen_mem !== exp_mem) fail({name, "_mem_access"}, 32'(seen_mem), 32'(exp_mem));
            if (!exp_mem) begin
               checks++; if (cyc != 1) fail({name, "_hit_latency"}, 32'(cyc), 32'd1);
            end
            done = 1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      mem_ack = 1'b0;
      if (!done) begin
         checks++; fail({name, "_timeout"}, 32'(cyc), 32'd50);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) fail({name, "_resp_pulse"}, 32'(resp_valid), 32'd0);
      checks++; if (req_ready  !== 1'b1) fail({name, "_back_idle"},  32'(req_ready),  32'd1);
      ack_wait = (ack_wait % 3) + 1;
   endtask

   task automatic test_reset();
      apply_reset("reset");
   endtask

   task automatic test_load_miss_fill();
      mem_model[32'h100] = 32'hDEAD_BEEF;
      issue("load_miss_100", 1'b0, 32'h100, 32'h0, 1'b1);
   endtask

   task automatic test_load_hit();
      issue("load_hit_100", 1'b0, 32'h100, 32'h0, 1'b0);
      issue("load_hit_103", 1'b0, 32'h103, 32'h0, 1'b0);   // byte offset ignored
   endtask

   task automatic test_store_hit();
      issue("store_hit_100",  1'b1, 32'h100, 32'h1234_5678, 1'b1);
      issue("load_after_st",  1'b0, 32'h100, 32'h0, 1'b0);
   endtask

   task automatic test_store_miss();
      issue("store_miss_200", 1'b1, 32'h200, 32'hAAAA_5555, 1'b1);
      issue("load_200_miss",  1'b0, 32'h200, 32'h0, 1'b1);   // store did not allocate
      issue("load_200_hit",   1'b0, 32'h200, 32'h0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int s = 1; s < 4; s++) issue("b2b_fill", 1'b0, 32'h100 + 32'(4 * s), 32'h0, 1'b1);
      for (int s = 0; s < 4; s++) issue("b2b_hit",  1'b0, 32'h100 + 32'(4 * s), 32'h0, 1'b0);
   endtask

   task automatic test_replacement();
      apply_reset("repl_reset");
      for (int t = 0; t < 4; t++) issue("repl_fill", 1'b0, 32'(16 * t), 32'h0, 1'b1);
      issue("repl_evict_040", 1'b0, 32'h040, 32'h0, 1'b1);  // pointer 0 -> way 0 (0x000)
      issue("repl_hit_010",   1'b0, 32'h010, 32'h0, 1'b0);
      issue("repl_hit_030",   1'b0, 32'h030, 32'h0, 1'b0);
      issue("repl_hit_040",   1'b0, 32'h040, 32'h0, 1'b0);
      issue("repl_miss_000",  1'b0, 32'h000, 32'h0, 1'b1);  // pointer 1 -> evicts 0x010
      issue("repl_miss_010",  1'b0, 32'h010, 32'h0, 1'b1);
      issue("repl_st_040",    1'b1, 32'h040, 32'hCAFE_F00D, 1'b1);
      issue("repl_ld_040",    1'b0, 32'h040, 32'h0, 1'b0);
   endtask

   task automatic test_idle_ack();
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++; if (resp_valid !== 1'b0) fail("idle_ack_resp", 32'(resp_valid), 32'd0);
      checks++; if (mem_req    !== 1'b0) fail("idle_ack_mem_req", 32'(mem_req), 32'd0);
      checks++; if (req_ready  !== 1'b1) fail("idle_ack_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic test_reset_mid_fill();
      bit stray;
      apply_reset("mid_pre_reset");
      issue("mid_fill_100", 1'b0, 32'h100, 32'h0, 1'b1);
      // Start a second miss and abandon it with reset while FILL is waiting.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h140;
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1) fail("mid_fill_started", 32'(mem_req), 32'd1);
      apply_reset("mid_fill_reset");
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ack = (i == 0);
         @(negedge clk);
         if (resp_valid) stray = 1;
      end
      mem_ack = 1'b0;
      checks++; if (stray !== 1'b0) fail("mid_fill_no_resp", 32'(stray), 32'd0);
      issue("mid_reload_100", 1'b0, 32'h100, 32'h0, 1'b1);
      issue("mid_rehit_100",  1'b0, 32'h100, 32'h0, 1'b0);
      issue("mid_miss_140",   1'b0, 32'h140, 32'h0, 1'b1);  // abandoned fill left no line
`ifdef MMU_DCACHE_PERF_EN
      checks++; if (perf_hits   !== 32'd1) fail("perf_hits",   perf_hits,   32'd1);
      checks++; if (perf_misses !== 32'd2) fail("perf_misses", perf_misses, 32'd2);
`endif
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      @(negedge clk);
      test_reset();
      test_load_miss_fill();
      test_load_hit();
      test_store_hit();
      test_store_miss();
      test_back_to_back();
      test_replacement();
      test_idle_ack();
      test_reset_mid_fill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
